uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- 6809-facing UART transmitter: the other direction from the serial receive path into the FPGA.
- Bytes written by the CPU to the UART data register are buffered in a FIFO, then serialized 8N1, LSB first, onto o_UART_RX, the FPGA line into the FT2232 RX pin.
- Sits under uart_interface, clocked by the internal OSCH clock.
- Bus-side write strobes come from the 6809 E-clock domain and are synchronized internally.

Parameters:
- CLKS_PER_BIT, 289: clk cycles per serial bit; 33.25 MHz / 115200 rounded. Legal range 2 to 65535.
- FIFO_DEPTH, 16: FIFO entries, power of two.
- ADDR_W, 4: log2(FIFO_DEPTH).

Ports:
- clk  in  1  internal oscillator clock.
- reset  in  1  asynchronous, active-low (6809 RESET).
- i_wr_en  in  1  asynchronous level, high while the CPU writes the data register (uart_data_ce && !i_RW && E).
- i_data  in  8  bus data; stable while i_wr_en is high.
- i_tx_enable  in  1  control-register bit; 0 holds the transmitter in IDLE.
- i_clear_overflow  in  1  one-cycle pulse that clears o_overflow.
- o_UART_RX  out  1  serial line, idle high.
- o_tx_busy  out  1  high while a frame is on the line.
- o_fifo_empty  out  1  FIFO holds 0 entries.
- o_fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- o_fifo_count  out  ADDR_W+1  number of entries held, 0 to FIFO_DEPTH.
- o_overflow  out  1  sticky; set when a write is dropped.

Behaviour:
- Reset (asynchronous, active-low). While reset is low:
  - o_UART_RX=1, o_tx_busy=0, o_fifo_empty=1, o_fifo_full=0, o_fifo_count=0, o_overflow=0.
  - FIFO pointers = 0, FSM = IDLE, synchronizer flops = 0.
  - Reset mid-frame aborts the frame; the line returns high immediately. No partial byte is resumed.
- Write capture:
  - i_wr_en passes through a 2-flop synchronizer plus an edge-detect flop.
  - A push request is the rising edge of the synchronized level: exactly one push per bus write, however long i_wr_en stays high.
  - i_data is sampled in the same cycle the edge is detected.
- Push rules:
  - If the FIFO is not full, the byte is written at wr_ptr and wr_ptr increments modulo FIFO_DEPTH. Pointers wrap naturally.
  - If the FIFO is full (evaluated before any same-cycle pop), the byte is dropped, o_overflow is set and the FIFO is unchanged.
  - o_overflow stays set until i_clear_overflow. If a set and a clear occur in the same cycle, set wins.
- Simultaneous push and pop on a non-full FIFO: both occur and the count is unchanged.
- FIFO status outputs (o_fifo_count, o_fifo_empty, o_fifo_full) are registered and update the cycle after a push or pop.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_UART_RX=1, o_tx_busy=0. If i_tx_enable=1 and FIFO not empty, pop into the shift register, clear the bit counter, go to START.
  - START: o_UART_RX=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: drive shift[0] for CLKS_PER_BIT cycles, shift right. After 8 bits go to STOP.
  - STOP: o_UART_RX=1 for CLKS_PER_BIT cycles, then IDLE.
  - o_tx_busy=1 in START, DATA and STOP.
- Latency: with the FIFO empty and the FSM in IDLE, push at cycle T gives:
  - pop at T+1;
  - o_UART_RX low from T+2;
  - frame length exactly 10*CLKS_PER_BIT cycles.
- Back-to-back frames: IDLE lasts exactly 1 cycle between frames (the pop cycle).
- i_tx_enable is sampled only in IDLE. Dropping it mid-frame completes the current frame.
- Baud counter width is 16 bits. It reloads to 0 at every state entry and counts to CLKS_PER_BIT-1.
- o_UART_RX is driven from a flop; no glitches.

Test Plan:
- CLKS_PER_BIT=4, enable=1: write 0x55 -> o_UART_RX low at T+2 for 4 clk, then bits 1,0,1,0,1,0,1,0 at 4 clk each, then high 4 clk. Total 40 cycles; o_tx_busy high exactly those 40 cycles.
- i_tx_enable=0: 16 writes 0x00..0x0F -> o_fifo_count=16, o_fifo_full=1. 17th write 0xAA -> dropped, o_overflow=1, count stays 16. Then i_clear_overflow -> o_overflow=0.
- Continue from the previous test, set enable=1 -> 16 frames carrying 0x00..0x0F in order, 1 idle cycle between frames. Ends with o_fifo_empty=1; 0xAA never appears.
- Hold i_wr_en high for 50 clk with data 0x3C -> exactly one push, count=1.
- Assert reset during DATA bit 3 of 0xF0 with 3 bytes queued -> o_UART_RX=1 immediately, count=0, busy=0. After release, no frame without a new write.
- Wrap test: push and pop 40 bytes at 0x80+n with enable=1 -> serialized order preserved across pointer wrap; no overflow flagged.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// CPU-facing UART transmitter: bus writes are synchronized into a byte FIFO,
// then serialized 8N1, LSB first, onto o_UART_RX.
module uart_tx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 289,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned ADDR_W       = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_wr_en,
   input  logic [7:0]      i_data,
   input  logic            i_tx_enable,
   input  logic            i_clear_overflow,
   output logic            o_UART_RX,
   output logic            o_tx_busy,
   output logic            o_fifo_empty,
   output logic            o_fifo_full,
   output logic [ADDR_W:0] o_fifo_count,
   output logic            o_overflow
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [15:0]     BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(FIFO_DEPTH);

   logic              wr_meta, wr_sync, wr_prev;
   logic              push_req, push, pop, full_now;
   logic [7:0]        mem [FIFO_DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   count, count_next;

   state_t            state, state_next;
   logic [15:0]       baud, baud_next;
   logic [2:0]        bit_idx, bit_next;
   logic [7:0]        shift, shift_next;
   logic              tx_next, busy_next, baud_done;

   // Two-flop synchronizer plus edge flop: one push per bus write cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_meta <= 1'b0;
         wr_sync <= 1'b0;
         wr_prev <= 1'b0;
      end else begin
         wr_meta <= i_wr_en;
         wr_sync <= wr_meta;
         wr_prev <= wr_sync;
      end
   end

   assign push_req = wr_sync & ~wr_prev;
   assign full_now = (count == COUNT_FULL);
   assign push     = push_req & ~full_now;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= i_data;
   end

   always_comb begin
      count_next = count;
      if (push && !pop)      count_next = count + 1'b1;
      else if (!push && pop) count_next = count - 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         o_fifo_empty <= 1'b1;
         o_fifo_full  <= 1'b0;
         o_overflow   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count        <= count_next;
         o_fifo_empty <= (count_next == '0);
         o_fifo_full  <= (count_next == COUNT_FULL);
         // A dropped write in the same cycle as a clear leaves the flag set
         if (push_req && full_now)  o_overflow <= 1'b1;
         else if (i_clear_overflow) o_overflow <= 1'b0;
      end
   end

   assign o_fifo_count = count;
   assign baud_done    = (baud == BAUD_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         baud      <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         o_UART_RX <= 1'b1;
         o_tx_busy <= 1'b0;
      end else begin
         state     <= state_next;
         baud      <= baud_next;
         bit_idx   <= bit_next;
         shift     <= shift_next;
         o_UART_RX <= tx_next;
         o_tx_busy <= busy_next;
      end
   end

   always_comb begin
      state_next = state;
      baud_next  = baud;
      bit_next   = bit_idx;
      shift_next = shift;
      pop        = 1'b0;
      unique case (state)
         IDLE: begin
            baud_next = '0;
            if (i_tx_enable && (count != '0)) begin
               pop        = 1'b1;
               shift_next = mem[rd_ptr];
               bit_next   = '0;
               state_next = START;
            end
         end
         START: begin
            if (baud_done) begin
               baud_next  = '0;
               state_next = DATA;
            end else begin
               baud_next = baud + 1'b1;
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_next  = '0;
               shift_next = {1'b0, shift[7:1]};
               bit_next   = bit_idx + 1'b1;
               if (bit_idx == 3'd7) state_next = STOP;
            end else begin
               baud_next = baud + 1'b1;
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_next  = '0;
               state_next = IDLE;
            end else begin
               baud_next = baud + 1'b1;
            end
         end
      endcase

      // Line level is computed for the next state so the output flop is glitch-free
      tx_next = 1'b1;
      unique case (state_next)
         IDLE:  tx_next = 1'b1;
         START: tx_next = 1'b0;
         DATA:  tx_next = shift_next[0];
         STOP:  tx_next = 1'b1;
      endcase
      busy_next = (state_next != IDLE);
   end

endmodule
